// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencing controller.
package pipe_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WCNT_W     = 8;

  typedef enum logic {
    PC_RUN      = 1'b0,
    PC_MEM_WAIT = 1'b1
  } pc_state_e;

  // Shadow of the instruction currently sitting in EX.
  typedef struct packed {
    logic                  valid;
    logic                  load;
    logic [REG_ADDR_W-1:0] rd;
  } ex_shadow_t;
endpackage

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencing for IF/ID/EX/MEM: load-use, taken jumps, and
// data-memory waits bounded by a timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs2,
  input  logic                  id_rmem,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  ex_jump_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  mem_timeout
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

  pc_state_e         state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              timeout_nxt;
  ex_shadow_t        ex_q;
  logic              lu, mw;

  always_comb begin
    lu = id_valid && ex_q.valid && ex_q.load && (ex_q.rd != '0) &&
         ((ex_q.rd == id_rs1_addr) || (id_uses_rs2 && (ex_q.rd == id_rs2_addr)));
    mw = ((state == PC_RUN) && mem_req && !mem_ready) ||
         ((state == PC_MEM_WAIT) && !mem_ready && (wcnt < WCNT_LAST));

    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    // Outputs are gated by reset so the pipe is never held while in reset.
    if (rst_n) begin
      if (mw) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (ex_jump_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (lu) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end

    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_nxt = 1'b0;
    case (state)
      PC_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = PC_MEM_WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      PC_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = PC_RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt   = PC_RUN;
          wcnt_nxt    = '0;
          timeout_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = PC_RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PC_RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
      ex_q        <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      mem_timeout <= timeout_nxt;
      // A bubble only clears valid; rd/load are don't-care once invalid.
      if (!stall_ex) begin
        if (flush_ex || !id_valid) ex_q.valid <= 1'b0;
        else ex_q <= '{valid: 1'b1, load: id_rmem, rd: id_rd_addr};
      end
    end
  end

endmodule
